// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one combinational ALU among
// N_REQ requesters. One operation is in flight at a time: a grant in IDLE,
// one cycle of ALU evaluation in EXEC, then the tagged result is held in RESP
// until the consumer accepts it.
module alu_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*32-1:0]  req_instr,
    input  logic [N_REQ*32-1:0]  req_a,
    input  logic [N_REQ*32-1:0]  req_b,
    output logic [31:0]          alu_instruction,
    output logic [31:0]          alu_reg_A,
    output logic [31:0]          alu_reg_B,
    input  logic [31:0]          alu_result,
    input  logic [2:0]           alu_flags,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_result,
    output logic [2:0]           rsp_flags,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [31:0]       instr_reg, instr_next;
    logic [31:0]       a_reg, a_next;
    logic [31:0]       b_reg, b_next;
    logic [ID_W-1:0]   id_reg, id_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [ID_W-1:0]   rsp_id_reg, rsp_id_next;
    logic [31:0]       rsp_result_reg, rsp_result_next;
    logic [2:0]        rsp_flags_reg, rsp_flags_next;
    logic [CNT_W-1:0]  op_count_reg, op_count_next;

    logic [31:0]       instr_lane [N_REQ];
    logic [31:0]       a_lane     [N_REQ];
    logic [31:0]       b_lane     [N_REQ];
    logic [N_REQ-1:0]  at_or_after_ptr;
    logic [N_REQ-1:0]  valid_masked;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [31:0]       sel_instr, sel_a, sel_b;

    // Unpack the flat request buses and mark requesters at or above rr_ptr.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
        assign instr_lane[gi]      = req_instr[32*gi +: 32];
        assign a_lane[gi]          = req_a[32*gi +: 32];
        assign b_lane[gi]          = req_b[32*gi +: 32];
        assign at_or_after_ptr[gi] = (ID_W'(gi) >= rr_ptr_reg);
        assign req_ready[gi]       = (state_reg == IDLE) && grant_found &&
                                     (grant_idx == ID_W'(gi));
    end

    assign valid_masked = req_valid & at_or_after_ptr;

    // Round-robin pick: lowest valid index at or above rr_ptr, else wrap to
    // the lowest valid index overall.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(i);
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (valid_masked[i]) begin
                grant_idx = ID_W'(i);
            end
        end
    end

    // Payload mux for the granted requester.
    always_comb begin
        sel_instr = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_instr = instr_lane[i];
                sel_a     = a_lane[i];
                sel_b     = b_lane[i];
            end
        end
    end

    // Next-state and datapath updates for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        instr_next      = instr_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        id_next         = id_reg;
        rsp_valid_next  = rsp_valid_reg;
        rsp_id_next     = rsp_id_reg;
        rsp_result_next = rsp_result_reg;
        rsp_flags_next  = rsp_flags_reg;
        op_count_next   = op_count_reg;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    instr_next  = sel_instr;
                    a_next      = sel_a;
                    b_next      = sel_b;
                    id_next     = grant_idx;
                    rr_ptr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_next  = EXEC;
                end
            end
            EXEC: begin
                rsp_result_next = alu_result;
                rsp_flags_next  = alu_flags;
                rsp_id_next     = id_reg;
                rsp_valid_next  = 1'b1;
                state_next      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    if (op_count_reg != {CNT_W{1'b1}}) begin
                        op_count_next = op_count_reg + 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            instr_reg      <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            id_reg         <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= '0;
            rsp_result_reg <= '0;
            rsp_flags_reg  <= '0;
            op_count_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            instr_reg      <= instr_next;
            a_reg          <= a_next;
            b_reg          <= b_next;
            id_reg         <= id_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_id_reg     <= rsp_id_next;
            rsp_result_reg <= rsp_result_next;
            rsp_flags_reg  <= rsp_flags_next;
            op_count_reg   <= op_count_next;
        end
    end

    assign alu_instruction = instr_reg;
    assign alu_reg_A       = a_reg;
    assign alu_reg_B       = b_reg;
    assign rsp_valid       = rsp_valid_reg;
    assign rsp_id          = rsp_id_reg;
    assign rsp_result      = rsp_result_reg;
    assign rsp_flags       = rsp_flags_reg;
    assign busy            = (state_reg != IDLE);
    assign op_count        = op_count_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the arbiter. A second
// instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_alu_arbiter;

    localparam int N  = 4;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_ready, req_ready_s;
    logic [N*32-1:0] req_instr, req_a, req_b;
    logic [31:0]     alu_instruction, alu_reg_A, alu_reg_B, alu_result;
    logic [2:0]      alu_flags;
    logic            rsp_valid, rsp_ready, busy;
    logic [IW-1:0]   rsp_id;
    logic [31:0]     rsp_result;
    logic [2:0]      rsp_flags;
    logic [15:0]     op_count;

    logic [31:0]     alu_instruction_s, alu_reg_A_s, alu_reg_B_s, alu_result_s;
    logic [2:0]      alu_flags_s;
    logic            rsp_valid_s, busy_s;
    logic [IW-1:0]   rsp_id_s;
    logic [31:0]     rsp_result_s;
    logic [2:0]      rsp_flags_s;
    logic [3:0]      op_count_s;

    alu_arbiter #(.N_REQ(N), .ID_W(IW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_instr(req_instr), .req_a(req_a), .req_b(req_b),
        .alu_instruction(alu_instruction), .alu_reg_A(alu_reg_A), .alu_reg_B(alu_reg_B),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .busy(busy), .op_count(op_count)
    );

    alu_arbiter #(.N_REQ(N), .ID_W(IW), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_s),
        .req_instr(req_instr), .req_a(req_a), .req_b(req_b),
        .alu_instruction(alu_instruction_s), .alu_reg_A(alu_reg_A_s), .alu_reg_B(alu_reg_B_s),
        .alu_result(alu_result_s), .alu_flags(alu_flags_s),
        .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready), .rsp_id(rsp_id_s),
        .rsp_result(rsp_result_s), .rsp_flags(rsp_flags_s),
        .busy(busy_s), .op_count(op_count_s)
    );

    // Behavioural MIPS-style ALU: returns {overflow, negative, zero, result}.
    function automatic logic [34:0] alu_fn(input logic [31:0] ins, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        logic        ov;
        r  = '0;
        ov = 1'b0;
        case (ins[5:0])
            6'h20: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            6'h22: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h2a: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return {ov, r[31], (r == 32'd0), r};
    endfunction

    assign {alu_flags, alu_result}     = alu_fn(alu_instruction, alu_reg_A, alu_reg_B);
    assign {alu_flags_s, alu_result_s} = alu_fn(alu_instruction_s, alu_reg_A_s, alu_reg_B_s);

    // Requester-side state: each requester holds valid and payload until granted.
    logic [N-1:0] vld;
    logic [31:0]  p_ins [N];
    logic [31:0]  p_a   [N];
    logic [31:0]  p_b   [N];

    always_comb begin
        req_valid = vld;
        req_instr = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) begin
            req_instr[32*i +: 32] = p_ins[i];
            req_a[32*i +: 32]     = p_a[i];
            req_b[32*i +: 32]     = p_b[i];
        end
    end

    // Transaction-level model.
    int          ph;          // 0 waiting for a grant, 1 operation in ALU, 2 result offered
    int          rr;
    logic [31:0] m_ins, m_a, m_b, m_res;
    logic [2:0]  m_fl;
    int          m_id;
    bit          m_rv;
    int          total;
    int          cyc;
    int          fill_mode;   // 0 none, 1 random, 2 always refill
    bit          rnd_rsp;
    int          grants[$];
    int          gcyc[$];
    int          granted;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        for (int k = 0; k < N; k++) begin
            if (vld[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        ph = 0; rr = 0; m_ins = '0; m_a = '0; m_b = '0; m_res = '0; m_fl = '0;
        m_id = 0; m_rv = 1'b0; total = 0;
    endtask

    task automatic rand_payload(input int i);
        logic [5:0] f;
        logic [31:0] corner [4];
        corner[0] = 32'h7FFF_FFFF; corner[1] = 32'h8000_0000;
        corner[2] = 32'h0;         corner[3] = 32'hFFFF_FFFF;
        case ($urandom_range(4, 0))
            0: f = 6'h20; 1: f = 6'h22; 2: f = 6'h24; 3: f = 6'h25; default: f = 6'h2a;
        endcase
        p_ins[i] = {6'b0, 15'($urandom), 5'b0, f};
        p_a[i]   = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(3, 0)] : $urandom;
        p_b[i]   = ($urandom_range(3, 0) == 0) ? corner[$urandom_range(3, 0)] : $urandom;
    endtask

    task automatic set_req(input int i, input logic [31:0] ins, input logic [31:0] a,
                           input logic [31:0] b);
        p_ins[i] = ins; p_a[i] = a; p_b[i] = b; vld[i] = 1'b1;
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_ready;
        int g;
        g = exp_grant();
        exp_ready = '0;
        if (ph == 0 && g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("req_ready_sat", 64'(req_ready_s), 64'(exp_ready));
        chk("busy", 64'(busy), 64'(ph != 0));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
        if (m_rv) begin
            chk("rsp_id", 64'(rsp_id), 64'(m_id));
            chk("rsp_result", 64'(rsp_result), 64'(m_res));
            chk("rsp_flags", 64'(rsp_flags), 64'(m_fl));
        end
        chk("alu_instruction", 64'(alu_instruction), 64'(m_ins));
        chk("alu_reg_A", 64'(alu_reg_A), 64'(m_a));
        chk("alu_reg_B", 64'(alu_reg_B), 64'(m_b));
        chk("op_count", 64'(op_count), 64'((total > 65535) ? 65535 : total));
        chk("op_count_sat", 64'(op_count_s), 64'((total > 15) ? 15 : total));
    endtask

    // Advance through one rising edge, update the model, then refresh stimulus.
    task automatic tail();
        @(posedge clk);
        granted = -1;
        case (ph)
            0: begin
                granted = exp_grant();
                if (granted >= 0) begin
                    m_ins = p_ins[granted]; m_a = p_a[granted]; m_b = p_b[granted];
                    m_id  = granted;
                    rr    = (granted + 1) % N;
                    ph    = 1;
                end
            end
            1: begin
                {m_fl, m_res} = alu_fn(m_ins, m_a, m_b);
                m_rv = 1'b1;
                ph   = 2;
            end
            default: begin
                if (rsp_ready) begin
                    m_rv = 1'b0;
                    total++;
                    ph = 0;
                end
            end
        endcase
        #1;
        cyc++;
        if (granted >= 0) begin
            vld[granted] = 1'b0;
            grants.push_back(granted);
            gcyc.push_back(cyc);
        end
        for (int i = 0; i < N; i++) begin
            if (!vld[i] && (fill_mode == 2 || (fill_mode == 1 && $urandom_range(2, 0) == 0))) begin
                rand_payload(i);
                vld[i] = 1'b1;
            end
        end
        if (rnd_rsp) rsp_ready = ($urandom_range(2, 0) != 0);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        tail();
    endtask

    initial begin
        vld = '0;
        for (int i = 0; i < N; i++) begin
            p_ins[i] = '0; p_a[i] = '0; p_b[i] = '0;
        end
        rsp_ready = 1'b1;
        fill_mode = 0;
        rnd_rsp   = 1'b0;
        cyc       = 0;
        rst_n     = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #2 check_outputs();
        @(negedge clk);
        #1 rst_n = 1'b1;
        tail();

        // Single add from requester 2.
        set_req(2, 32'h0001_0020, 32'd5, 32'd7);
        #1 chk("add_ready", 64'(req_ready), 64'(4'b0100));
        cycle();
        cycle();
        chk("add_valid", 64'(rsp_valid), 64'd1);
        chk("add_id", 64'(rsp_id), 64'd2);
        chk("add_res", 64'(rsp_result), 64'd12);
        chk("add_flags", 64'(rsp_flags), 64'(3'b000));
        cycle();
        chk("add_count", 64'(op_count), 64'd1);

        // Signed overflow, then a subtract giving zero.
        set_req(0, 32'h0001_0020, 32'h7FFF_FFFF, 32'd1);
        cycle();
        cycle();
        chk("ovf_res", 64'(rsp_result), 64'h8000_0000);
        chk("ovf_flags", 64'(rsp_flags), 64'(3'b110));
        cycle();
        set_req(0, 32'h0001_0022, 32'd9, 32'd9);
        cycle();
        cycle();
        chk("sub_res", 64'(rsp_result), 64'd0);
        chk("sub_flags", 64'(rsp_flags), 64'(3'b001));
        cycle();

        // Backpressure: result held for 5 cycles, then released.
        rsp_ready = 1'b0;
        set_req(1, 32'h0001_0025, 32'h0000_00F0, 32'h0000_000F);
        cycle();
        cycle();
        repeat (5) cycle();
        chk("bp_valid", 64'(rsp_valid), 64'd1);
        chk("bp_res", 64'(rsp_result), 64'hFF);
        chk("bp_id", 64'(rsp_id), 64'd1);
        chk("bp_count", 64'(op_count), 64'd3);
        rsp_ready = 1'b1;
        cycle();
        chk("bp_idle", 64'(busy), 64'd0);
        chk("bp_count_after", 64'(op_count), 64'd4);

        // Reset while an operation sits in EXEC.
        set_req(3, 32'h0001_0020, 32'd100, 32'd23);
        cycle();
        chk("mid_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        vld   = '0;
        model_reset();
        #1 check_outputs();
        @(negedge clk);
        #1 rst_n = 1'b1;
        tail();

        // All requesters continuously valid: strict rotation from requester 0.
        grants.delete();
        gcyc.delete();
        fill_mode = 2;
        for (int i = 0; i < N; i++) begin
            rand_payload(i);
            vld[i] = 1'b1;
        end
        repeat (18) cycle();
        if (grants.size() < 6) begin
            chk("rr_grant_count", 64'(grants.size()), 64'd6);
        end else begin
            int exp_order [6];
            exp_order = '{0, 1, 2, 3, 0, 1};
            for (int i = 0; i < 6; i++) chk("rr_order", 64'(grants[i]), 64'(exp_order[i]));
            for (int i = 1; i < 6; i++) chk("rr_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'd3);
        end

        // Random traffic with random response backpressure.
        fill_mode = 1;
        rnd_rsp   = 1'b1;
        repeat (300) cycle();
        rnd_rsp   = 1'b0;
        rsp_ready = 1'b1;
        fill_mode = 0;
        repeat (6) cycle();
        chk("sat_final", 64'(op_count_s), 64'((total > 15) ? 15 : total));
        chk("sat_reached", 64'(total > 15), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
